// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared types and constants for the push-button conditioner.
// Build option: KEY_AUTOREPEAT_EN (used by key_channel) enables auto-repeat.
package key_cond_pkg;

   // Per-channel debounce state
   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } key_state_e;

   // Number of DE1 push buttons handled
   localparam int NUM_KEYS = 4;

   // Counter width able to hold max_count with one bit of headroom
   function automatic int cnt_width(input int max_count);
      return $clog2(max_count) + 1;
   endfunction

endpackage

// File: rtl/key_channel.sv
// key_channel: one push button -> two-flop synchronizer, stable-count debounce
// FSM, registered debounced level and single-cycle press strobe.
// Build option: KEY_AUTOREPEAT_EN adds a repeat counter that re-issues press
// strobes while the key stays accepted.
module key_channel
   import key_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 5_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic held,
   output logic press
);

   // One width shared by the debounce and repeat counters
   localparam int RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int MAX_COUNT = (DEBOUNCE_CYCLES > RPT_MAX) ? DEBOUNCE_CYCLES : RPT_MAX;
   localparam int CNT_W     = cnt_width(MAX_COUNT);

   // Counter value on the last of DEBOUNCE_CYCLES consecutive stable samples
   // (the entry sample into a *_WAIT state is the first, with counter at 0)
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

   logic       s1_q, s1_d;
   logic       s2_q, s2_d;
   key_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic       held_q, held_d;
   logic       press_q, press_d;

`ifdef KEY_AUTOREPEAT_EN
   // Repeat counter counts down; a strobe fires when it is 0 in PRESSED
   localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD - 1);
   logic [CNT_W-1:0] rpt_q, rpt_d;
`endif

   // Next-state logic: synchronizer shift, debounce FSM, counters and strobes
   always_comb begin
      s1_d    = ~key_n;
      s2_d    = s1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rpt_d   = rpt_q;
`endif
      case (state_q)
         ST_RELEASED: begin
            if (s2_q) begin
               state_d = ST_PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         ST_PRESS_WAIT: begin
            if (!s2_q) begin
               state_d = ST_RELEASED;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
               press_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
               rpt_d   = RPT_FIRST;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_PRESSED: begin
            if (!s2_q) begin
               state_d = ST_RELEASE_WAIT;
               cnt_d   = '0;
`ifdef KEY_AUTOREPEAT_EN
               rpt_d   = '0;
            end else if (rpt_q == '0) begin
               press_d = 1'b1;
               rpt_d   = RPT_NEXT;
            end else begin
               rpt_d = rpt_q - 1'b1;
`endif
            end
         end
         ST_RELEASE_WAIT: begin
            if (s2_q) begin
               // Bounce back: level stays pressed, no new initial strobe
               state_d = ST_PRESSED;
               cnt_d   = '0;
`ifdef KEY_AUTOREPEAT_EN
               rpt_d   = RPT_FIRST;
`endif
            end else if (cnt_q == DB_LAST) begin
               state_d = ST_RELEASED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
         end
      endcase
      held_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
   end

   // State and output registers, asynchronously cleared
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= ST_RELEASED;
         cnt_q   <= '0;
         held_q  <= 1'b0;
         press_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
         rpt_q   <= '0;
`endif
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         held_q  <= held_d;
         press_q <= press_d;
`ifdef KEY_AUTOREPEAT_EN
         rpt_q   <= rpt_d;
`endif
      end
   end

   assign held  = held_q;
   assign press = press_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: conditions the four active-low DE1 push buttons into
// debounced active-high levels (held) and one-cycle press strobes (press).
// Build option: KEY_AUTOREPEAT_EN enables auto-repeat strobes while held.
module key_conditioner
   import key_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 5_000_000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] KEY,
   output logic [NUM_KEYS-1:0] held,
   output logic [NUM_KEYS-1:0] press
);

   // Independent channel per key
   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
      key_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
         .clk   (clk),
         .reset (reset),
         .key_n (KEY[gi]),
         .held  (held[gi]),
         .press (press[gi])
      );
   end

endmodule
